l1_l2_req_scheduler: RTL and testbench
======================================

// Module: l1_l2_req_scheduler
// PURPOSE
//  Shares the single L1->L2 cache request channel between the I-cache and the D-cache.
//  The D-cache request comes already arbitrated, either MSHR or WB buffer.
//  The D-cache has priority by default. An aging counter stops the I-cache from starving.
//  The winning request is registered in a one-entry output stage, so the L2 channel is driven from flops.
//  The block sits between the L1 caches and the L2 cache request port.
// PARAMETERS
//  REQ_W      default 128  width of the request payload (addr+type+data, same format for both sources)
//  STARVE_TH  default 4    I-cache wait cycles after which the I-cache gets priority (must be >=1)
//  CNT_W      default 3    width of the aging counter (must satisfy 2**CNT_W > STARVE_TH)
// PORTS
//  clk_i              in   1      clock
//  rst_i              in   1      asynchronous reset, active high
//  ic_req_valid_i     in   1      I-cache request valid
//  ic_req_i           in   REQ_W  I-cache request payload
//  ic_req_rdy_o       out  1      I-cache request accepted this cycle
//  dc_req_valid_i     in   1      D-cache (MSHR/WBB winner) request valid
//  dc_req_i           in   REQ_W  D-cache request payload
//  dc_req_rdy_o       out  1      D-cache request accepted this cycle
//  l2c_req_valid_o    out  1      output stage holds a request
//  l2c_req_o          out  REQ_W  registered request payload
//  l2c_req_src_o      out  1      source of held request: 0 = D-cache, 1 = I-cache
//  l2c_req_rdy_i      in   1      L2 cache accepts the request
// BEHAVIOUR
//  Reset (async, rst_i=1):
//   - l2c_req_valid_o=0, l2c_req_o=0, l2c_req_src_o=0, aging counter=0.
//   - ic_req_rdy_o and dc_req_rdy_o are combinational. During reset they are 0, because no grant is issued while rst_i is high.
//  Output stage FSM:
//   - EMPTY: l2c_req_valid_o=0.
//     - An accepted input moves the FSM to FULL on the next edge.
//   - FULL: l2c_req_valid_o=1; payload and source are held stable until l2c_req_rdy_i=1.
//     - l2c_req_rdy_i=1 with a new acceptance in the same cycle: stay FULL with the new payload (back-to-back, 1 req/cycle).
//     - l2c_req_rdy_i=1 with no new acceptance: go to EMPTY.
//  slot_free = !l2c_req_valid_o || l2c_req_rdy_i (combinational).
//  Grant (combinational, evaluated every cycle):
//   - Only ic valid -> IC. Only dc valid -> DC. Neither -> no grant.
//   - Both valid: IC if aging counter >= STARVE_TH, else DC.
//   - ic_req_rdy_o = slot_free && grant==IC. dc_req_rdy_o = slot_free && grant==DC. At most one rdy is high per cycle.
//   - Input handshake is valid&&rdy. A rdy may depend on the valid inputs. A valid must not depend on its rdy.
//  Latency: an accepted input appears on l2c_req_o on the next cycle. The minimum input-to-L2 latency is 1 cycle.
//  Aging counter (CNT_W bits):
//   - Cleared to 0 when ic_req_valid_i=0, or when the I-cache is accepted.
//   - Otherwise, with ic valid and not accepted, it increments and saturates at STARVE_TH (never wraps).
//   - It increments even when slot_free=0, so back-pressure counts toward aging.
//  Simultaneous events:
//   - Both requesters valid with L2 ready: exactly one is accepted. The loser keeps its valid, and the other rdy stays 0.
//   - Acceptance at saturation clears the counter in the same edge as the capture.
//   - The D-cache then wins the next tie, unless the I-cache wait starts over.
//  Back-pressure: if l2c_req_rdy_i=0 while FULL, both rdy=0. Payload, source and valid do not change.
//  Reset mid-operation: a held request is dropped (valid=0 immediately, asynchronously). The requesters re-issue it after reset.
//  No assumptions on L2 ready timing. l2c_req_rdy_i has no effect while EMPTY.
// TESTING
//  1. Reset with rst_i=1 and both valid=1 -> l2c_req_valid_o=0, both rdy=0. Release reset -> dc accepted first cycle.
//  2. Only ic valid, ic_req_i=0xA5, L2 rdy=1 -> ic_req_rdy_o=1 at cycle 0.
//     Cycle 1: l2c_req_o=0xA5, l2c_req_src_o=1.
//  3. Both valid continuously, L2 rdy=1, STARVE_TH=4 -> dc is accepted for 4 cycles, then ic in cycle 5.
//     After that, dc is accepted 4 more cycles (repeating pattern).
//  4. FULL with l2c_req_rdy_i=0 for 3 cycles -> payload is held and both rdy=0.
//     The I-cache counter still saturates at 4. On rdy=1, ic wins the tie.
//  5. Back-to-back: dc valid every cycle with payloads 1,2,3, L2 rdy=1 -> l2c_req_o shows 1,2,3 on consecutive cycles.
//     No bubble and no duplicate.
//  6. Assert rst_i while FULL with src=1 -> l2c_req_valid_o drops without waiting for a clock.
//     The counter reads 0 after reset.

Source files
------------

// File: rtl/l1_l2_req_scheduler.sv
// -----------------------------------------------------------------------------
// l1_l2_req_scheduler
//
// Purpose:
//   Shares the single L1->L2 request channel between the I-cache and the
//   D-cache. The D-cache request arrives already arbitrated (MSHR or write-back
//   buffer) and wins ties by default. An aging counter tracks how long a valid
//   I-cache request has been waiting. Once it reaches STARVE_TH, the I-cache
//   wins the next tie. The winner is captured in a one-entry output stage, so
//   the L2 channel is driven straight from flops.
//
// Parameters:
//   REQ_W      request payload width (same format for both sources)
//   STARVE_TH  I-cache wait cycles before it takes priority (>= 1)
//   CNT_W      aging counter width (2**CNT_W > STARVE_TH)
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   ic_req_valid_i / ic_req_i        I-cache request and payload
//   ic_req_rdy_o                     I-cache request accepted this cycle
//   dc_req_valid_i / dc_req_i        D-cache request and payload
//   dc_req_rdy_o                     D-cache request accepted this cycle
//   l2c_req_valid_o                  output stage holds a request
//   l2c_req_o                        registered request payload
//   l2c_req_src_o                    source of held request (0 = DC, 1 = IC)
//   l2c_req_rdy_i                    L2 accepts the held request
// -----------------------------------------------------------------------------
module l1_l2_req_scheduler #(
    parameter int REQ_W     = 128,
    parameter int STARVE_TH = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ic_req_valid_i,
    input  logic [REQ_W-1:0] ic_req_i,
    output logic             ic_req_rdy_o,
    input  logic             dc_req_valid_i,
    input  logic [REQ_W-1:0] dc_req_i,
    output logic             dc_req_rdy_o,
    output logic             l2c_req_valid_o,
    output logic [REQ_W-1:0] l2c_req_o,
    output logic             l2c_req_src_o,
    input  logic             l2c_req_rdy_i
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] STARVE_TH_C = CNT_W'(STARVE_TH);
    localparam logic [CNT_W-1:0] AGE_ONE_C   = CNT_W'(1'b1);
    localparam logic             SRC_DC_C    = 1'b0;
    localparam logic             SRC_IC_C    = 1'b1;

    state_t             state_q, state_d;
    logic [REQ_W-1:0]   payload_q, payload_d;
    logic               src_q, src_d;
    logic [CNT_W-1:0]   age_q, age_d;

    logic               slot_free_s;
    logic               grant_ic_s;
    logic               grant_dc_s;
    logic               accept_ic_s;
    logic               accept_dc_s;
    logic               accept_s;

    // Grant selection and acceptance for the current cycle
    always_comb begin
        slot_free_s = 1'b0;
        grant_ic_s  = 1'b0;
        grant_dc_s  = 1'b0;

        if (state_q == ST_EMPTY) begin
            slot_free_s = 1'b1;
        end else begin
            slot_free_s = l2c_req_rdy_i;
        end

        // The I-cache wins when it is alone or when it has waited long enough.
        // The D-cache wins every other case in which it is valid.
        if (ic_req_valid_i && (!dc_req_valid_i || (age_q >= STARVE_TH_C))) begin
            grant_ic_s = 1'b1;
        end else if (dc_req_valid_i) begin
            grant_dc_s = 1'b1;
        end else begin
            grant_ic_s = 1'b0;
            grant_dc_s = 1'b0;
        end
    end

    assign accept_ic_s = slot_free_s && grant_ic_s;
    assign accept_dc_s = slot_free_s && grant_dc_s;
    assign accept_s    = accept_ic_s || accept_dc_s;

    // The ready outputs are forced low while reset is high. The masking is kept
    // off the internal accept path, so rst_i never feeds a flop data input.
    assign ic_req_rdy_o = accept_ic_s && !rst_i;
    assign dc_req_rdy_o = accept_dc_s && !rst_i;

    // Output stage next state: capture on accept, drain on L2 ready
    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        src_d     = src_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // A new accept in the same cycle as the L2 handshake keeps the
                // stage full, which sustains one request per cycle.
                if (accept_s) begin
                    state_d = ST_FULL;
                end else if (l2c_req_rdy_i) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (accept_ic_s) begin
            payload_d = ic_req_i;
            src_d     = SRC_IC_C;
        end else if (accept_dc_s) begin
            payload_d = dc_req_i;
            src_d     = SRC_DC_C;
        end else begin
            payload_d = payload_q;
            src_d     = src_q;
        end
    end

    // Aging counter next state: count I-cache waiting cycles, saturating at STARVE_TH
    always_comb begin
        age_d = age_q;
        // Waiting also counts while the L2 is back-pressuring. Acceptance
        // clears the count on the same edge that captures the request, so
        // the D-cache wins the following tie again.
        if (!ic_req_valid_i || accept_ic_s) begin
            age_d = '0;
        end else if (age_q < STARVE_TH_C) begin
            age_d = age_q + AGE_ONE_C;
        end else begin
            age_d = STARVE_TH_C;
        end
    end

    // State, payload, source and aging registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_EMPTY;
            payload_q <= '0;
            src_q     <= 1'b0;
            age_q     <= '0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            src_q     <= src_d;
            age_q     <= age_d;
        end
    end

    assign l2c_req_valid_o = (state_q == ST_FULL);
    assign l2c_req_o       = payload_q;
    assign l2c_req_src_o   = src_q;

endmodule

// File: tb/tb_l1_l2_req_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for l1_l2_req_scheduler.
// The bench runs four phases:
//   - hand-written reset sequence
//   - table of directed vectors
//   - asynchronous reset applied while the output stage is full
//   - random phase checked against a queue-based reference model
// -----------------------------------------------------------------------------
module tb_l1_l2_req_scheduler;

    localparam int W  = 16;
    localparam int TH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_v, dc_v, l2_rdy;
    logic [W-1:0] ic_d, dc_d;
    logic         ic_rdy, dc_rdy, l2_v, l2_src;
    logic [W-1:0] l2_d;

    int checks = 0;
    int errors = 0;

    l1_l2_req_scheduler #(.REQ_W(W), .STARVE_TH(TH), .CNT_W(3)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ic_req_valid_i (ic_v),
        .ic_req_i       (ic_d),
        .ic_req_rdy_o   (ic_rdy),
        .dc_req_valid_i (dc_v),
        .dc_req_i       (dc_d),
        .dc_req_rdy_o   (dc_rdy),
        .l2c_req_valid_o(l2_v),
        .l2c_req_o      (l2_d),
        .l2c_req_src_o  (l2_src),
        .l2c_req_rdy_i  (l2_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         ic_v;
        logic [W-1:0] ic_d;
        logic         dc_v;
        logic [W-1:0] dc_d;
        logic         l2_rdy;
        logic         e_ic_rdy;
        logic         e_dc_rdy;
        logic         e_l2_v;
        logic [W-1:0] e_d;
        logic         e_src;
    } vec_t;

    vec_t tbl [21];

    // Reference model: a held-request queue (depth 1) plus an I-cache wait count
    typedef struct { logic [W-1:0] d; logic src; } held_t;
    held_t m_q[$];
    int    m_wait;

    initial begin
        // ---------------- vector table ----------------
        // Each row gives the inputs for one cycle and the outputs expected in that cycle.
        // ic request alone; it appears on the L2 side one cycle later
        tbl[0]  = '{1'b1, 16'h00A5, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00A5, 1'b1};
        // dc back-to-back with payloads 1, 2, 3
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        // both valid: four dc accepts, then ic, then dc again
        tbl[7]  = '{1'b1, 16'h0099, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[8]  = '{1'b1, 16'h0099, 1'b1, 16'h0021, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0020, 1'b0};
        tbl[9]  = '{1'b1, 16'h0099, 1'b1, 16'h0022, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0021, 1'b0};
        tbl[10] = '{1'b1, 16'h0099, 1'b1, 16'h0023, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0022, 1'b0};
        tbl[11] = '{1'b1, 16'h0099, 1'b1, 16'h0024, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0023, 1'b0};
        tbl[12] = '{1'b1, 16'h0099, 1'b1, 16'h0024, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0099, 1'b1};
        tbl[13] = '{1'b1, 16'h0099, 1'b1, 16'h0025, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0024, 1'b0};
        // back-pressure: payload held, aging saturates, then ic wins the tie
        tbl[14] = '{1'b1, 16'h0099, 1'b1, 16'h0026, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0025, 1'b0};
        tbl[15] = '{1'b1, 16'h0099, 1'b1, 16'h0026, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0025, 1'b0};
        tbl[16] = '{1'b1, 16'h0099, 1'b1, 16'h0026, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0025, 1'b0};
        tbl[17] = '{1'b1, 16'h0099, 1'b1, 16'h0026, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0025, 1'b0};
        tbl[18] = '{1'b0, 16'h0000, 1'b1, 16'h0026, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0099, 1'b1};
        tbl[19] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0026, 1'b0};
        tbl[20] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};

        // ---------------- reset with both requesters valid ----------------
        rst = 1'b1; ic_v = 1'b1; ic_d = 16'h000C; dc_v = 1'b1; dc_d = 16'h000D; l2_rdy = 1'b1;
        #12;
        chk("rst_l2_valid", l2_v, 1'b0);
        chk("rst_ic_rdy", ic_rdy, 1'b0);
        chk("rst_dc_rdy", dc_rdy, 1'b0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("post_rst_dc_rdy", dc_rdy, 1'b1);
        chk("post_rst_ic_rdy", ic_rdy, 1'b0);
        @(posedge clk); #1;
        ic_v = 1'b0; dc_v = 1'b0;
        #2;
        chk("post_rst_l2_valid", l2_v, 1'b1);
        chk("post_rst_l2_data", l2_d, 16'h000D);
        chk("post_rst_l2_src", l2_src, 1'b0);

        // ---------------- table ----------------
        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            ic_v = tbl[i].ic_v; ic_d = tbl[i].ic_d;
            dc_v = tbl[i].dc_v; dc_d = tbl[i].dc_d;
            l2_rdy = tbl[i].l2_rdy;
            #2;
            chk($sformatf("vec%0d_ic_rdy", i), ic_rdy, tbl[i].e_ic_rdy);
            chk($sformatf("vec%0d_dc_rdy", i), dc_rdy, tbl[i].e_dc_rdy);
            chk($sformatf("vec%0d_l2_valid", i), l2_v, tbl[i].e_l2_v);
            if (tbl[i].e_l2_v) begin
                chk($sformatf("vec%0d_l2_data", i), l2_d, tbl[i].e_d);
                chk($sformatf("vec%0d_l2_src", i), l2_src, tbl[i].e_src);
            end
        end

        // ---------------- async reset while full with src=1 ----------------
        @(posedge clk); #1;
        ic_v = 1'b1; ic_d = 16'h005A; dc_v = 1'b0; l2_rdy = 1'b0;
        @(posedge clk); #1;
        dc_v = 1'b1; dc_d = 16'h0077;
        // The ic request waits under back-pressure until its aging count saturates
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        chk("full_src_ic", l2_src, 1'b1);
        chk("full_data", l2_d, 16'h005A);
        chk("full_valid", l2_v, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_drop_valid", l2_v, 1'b0);
        chk("async_rst_ic_rdy", ic_rdy, 1'b0);
        l2_rdy = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        // With the aging count cleared, the D-cache must win the tie
        chk("age_cleared_dc_wins", dc_rdy, 1'b1);
        chk("age_cleared_ic_loses", ic_rdy, 1'b0);

        // ---------------- random phase against reference model ----------------
        @(posedge clk); #1;
        ic_v = 1'b0; dc_v = 1'b0; l2_rdy = 1'b0;
        rst = 1'b1;
        #2;
        @(negedge clk); rst = 1'b0;
        m_q.delete();
        m_wait = 0;
        for (int c = 0; c < 400; c++) begin
            logic e_ic, e_dc, free, gic;
            @(posedge clk);
            // Advance the model using the inputs that were sampled at this edge
            if (c > 0) begin
                free = (m_q.size() == 0) || l2_rdy;
                gic  = ic_v && (!dc_v || m_wait >= TH);
                e_ic = free && gic;
                e_dc = free && dc_v && !gic;
                if (m_q.size() > 0 && l2_rdy) m_q.pop_front();
                if (e_ic || e_dc) begin
                    if (m_q.size() > 0) m_q.pop_front();
                    m_q.push_back('{e_ic ? ic_d : dc_d, e_ic});
                end
                if (!ic_v || e_ic) m_wait = 0;
                else if (m_wait < TH) m_wait = m_wait + 1;
            end
            #1;
            ic_v   = ($urandom_range(0, 9) < 6);
            dc_v   = ($urandom_range(0, 9) < 6);
            l2_rdy = ($urandom_range(0, 9) < 7);
            ic_d   = W'($urandom);
            dc_d   = W'($urandom);
            #2;
            free = (m_q.size() == 0) || l2_rdy;
            gic  = ic_v && (!dc_v || m_wait >= TH);
            e_ic = free && gic;
            e_dc = free && dc_v && !gic;
            chk("rnd_ic_rdy", ic_rdy, e_ic);
            chk("rnd_dc_rdy", dc_rdy, e_dc);
            chk("rnd_l2_valid", l2_v, (m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("rnd_l2_data", l2_d, m_q[0].d);
                chk("rnd_l2_src", l2_src, m_q[0].src);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Time limit in case the stimulus stops advancing
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
